// File: rtl/load_store_unit.sv
// load_store_unit: aligns and formats byte/half/word loads and stores onto a
// valid/ready word bus, stalling the core until the access completes.
package load_store_pkg;
  typedef enum logic [3:0] {
    LS_N_A, L_B, L_H, L_W, L_BU, L_HU, S_B, S_H, S_W
  } load_store_type_e;
endpackage

module load_store_unit
  import load_store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  load_store_type_e load_store_type_i,
  input  logic             data_memory_write_enable_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  store_data_i,
  output logic             stall_o,
  output logic [XLEN-1:0]  load_data_o,
  output logic             misaligned_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [XLEN-1:0]  mem_req_addr_o,
  output logic             mem_req_we_o,
  output logic [3:0]       mem_req_be_o,
  output logic [XLEN-1:0]  mem_req_wdata_o,
  input  logic             mem_rsp_valid_i,
  input  logic [XLEN-1:0]  mem_rsp_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_e;
  state_e           r_state, w_next;
  load_store_type_e r_type;
  logic [1:0]       r_off;
  logic [XLEN-1:0]  r_addr, r_wdata, r_load_data;
  logic [3:0]       r_be;
  logic             r_we;
  logic             w_is_load, w_is_store, w_present, w_misaligned, w_start;
  logic [3:0]       w_be;
  logic [XLEN-1:0]  w_wdata, w_fmt;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  assign w_is_load    = load_store_type_i inside {L_B, L_H, L_W, L_BU, L_HU};
  assign w_is_store   = (load_store_type_i inside {S_B, S_H, S_W}) && data_memory_write_enable_i;
  assign w_present    = w_is_load || w_is_store;
  assign w_misaligned = ((load_store_type_i inside {L_H, L_HU, S_H}) && addr_i[0]) ||
                        ((load_store_type_i inside {L_W, S_W}) && (addr_i[1:0] != 2'b00));
  assign w_start      = (r_state == IDLE) && w_present && !w_misaligned;
  // Loads always fetch the full word; lane selection happens on the response.
  assign w_be    = load_store_type_i == S_B ? 4'b0001 << addr_i[1:0] :
                   load_store_type_i == S_H ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata = load_store_type_i == S_B ? {4{store_data_i[7:0]}} :
                   load_store_type_i == S_H ? {2{store_data_i[15:0]}} : store_data_i;
  assign w_byte  = mem_rsp_rdata_i[8*r_off +: 8];
  assign w_half  = r_off[1] ? mem_rsp_rdata_i[31:16] : mem_rsp_rdata_i[15:0];
  assign w_fmt   = r_type == L_B  ? {{24{w_byte[7]}}, w_byte} :
                   r_type == L_BU ? {24'b0, w_byte} :
                   r_type == L_H  ? {{16{w_half[15]}}, w_half} :
                   r_type == L_HU ? {16'b0, w_half} : mem_rsp_rdata_i;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_start ? REQ : IDLE;
      REQ:      w_next = mem_req_ready_i ? (r_we ? DONE : WAIT_RSP) : REQ;
      WAIT_RSP: w_next = mem_rsp_valid_i ? DONE : WAIT_RSP;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_type      <= LS_N_A;
      r_off       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_type  <= load_store_type_i;
        r_off   <= addr_i[1:0];
        r_addr  <= {addr_i[XLEN-1:2], 2'b00};
        r_we    <= w_is_store;
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
      if (r_state == WAIT_RSP && mem_rsp_valid_i) r_load_data <= w_fmt;
    end
  end
  assign stall_o         = w_start || (r_state == REQ) || (r_state == WAIT_RSP);
  assign misaligned_o    = (r_state == IDLE) && w_present && w_misaligned;
  assign mem_req_valid_o = r_state == REQ;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_we_o    = r_we;
  assign mem_req_be_o    = r_be;
  assign mem_req_wdata_o = r_wdata;
  assign load_data_o     = r_load_data;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random accesses against a byte-lane reference model.
module tb_load_store_unit;
  import load_store_pkg::*;
  logic             clk = 1'b0, rst_n = 1'b0;
  load_store_type_e ltype = LS_N_A;
  logic             wen = 1'b0, ready = 1'b0, rsp_v = 1'b0;
  logic [31:0]      a = '0, sdat = '0, rsp_d = '0;
  logic             stall, misaligned, valid, we;
  logic [31:0]      load_data, maddr, wdata;
  logic [3:0]       be;
  int               n_err = 0, n_chk = 0;
  logic [31:0]      exp_ld = '0;
  always #5 clk = ~clk;
  load_store_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .load_store_type_i(ltype),
    .data_memory_write_enable_i(wen), .addr_i(a), .store_data_i(sdat),
    .stall_o(stall), .load_data_o(load_data), .misaligned_o(misaligned),
    .mem_req_valid_o(valid), .mem_req_ready_i(ready), .mem_req_addr_o(maddr),
    .mem_req_we_o(we), .mem_req_be_o(be), .mem_req_wdata_o(wdata),
    .mem_rsp_valid_i(rsp_v), .mem_rsp_rdata_i(rsp_d)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int size_of(input load_store_type_e t);
    if (t == L_B || t == L_BU || t == S_B) return 1;
    if (t == L_H || t == L_HU || t == S_H) return 2;
    return 4;
  endfunction
  function automatic logic [31:0] fmt(input load_store_type_e t, input int off, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * off);
    if (size_of(t) == 1) begin
      v = v & 32'hFF;
      if (t == L_B && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size_of(t) == 2) begin
      v = v & 32'hFFFF;
      if (t == L_H && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction
  task automatic access(input load_store_type_e t, input logic w, input logic [31:0] ad,
                        input logic [31:0] sd, input int rdy_lat, input int rsp_lat,
                        input logic [31:0] rd);
    bit ld, st, pres, mis;
    int sz, off;
    logic [31:0] ebe, ewd;
    ld   = t inside {L_B, L_H, L_W, L_BU, L_HU};
    st   = (t inside {S_B, S_H, S_W}) && w;
    pres = ld || st;
    sz   = size_of(t);
    off  = int'(ad % 4);
    mis  = pres && (ad % sz != 0);
    ebe  = ld ? 32'hF : ((32'd1 << sz) - 1) << off;
    ewd  = sz == 1 ? sd[7:0] * 32'h0101_0101 : sz == 2 ? sd[15:0] * 32'h0001_0001 : sd;
    @(negedge clk);
    ltype = t; wen = w; a = ad; sdat = sd; ready = 1'($urandom_range(0, 1));
    rsp_v = 1'($urandom_range(0, 1)); rsp_d = $urandom;
    #1;
    chk("idle_mis", 32'(misaligned), 32'(mis));
    chk("idle_stall", 32'(stall), 32'(pres && !mis));
    chk("idle_valid", 32'(valid), 0);
    chk("idle_ld_hold", load_data, exp_ld);
    if (pres && !mis) begin
      for (int k = 0; k <= rdy_lat; k++) begin
        @(negedge clk);
        ready = (k == rdy_lat); rsp_v = 1'($urandom_range(0, 1)); rsp_d = $urandom;
        #1;
        chk("req_valid", 32'(valid), 1);
        chk("req_stall", 32'(stall), 1);
        chk("req_addr", maddr, ad & ~32'h3);
        chk("req_we", 32'(we), 32'(st));
        chk("req_be", 32'(be), ebe);
        if (st) chk("req_wdata", wdata, ewd);
        chk("req_ld_hold", load_data, exp_ld);
      end
      if (ld) begin
        for (int k = 1; k <= rsp_lat; k++) begin
          @(negedge clk);
          ready = 1'($urandom_range(0, 1)); rsp_v = (k == rsp_lat);
          rsp_d = (k == rsp_lat) ? rd : $urandom;
          #1;
          chk("wait_stall", 32'(stall), 1);
          chk("wait_valid", 32'(valid), 0);
        end
        exp_ld = fmt(t, off, rd);
      end
      @(negedge clk);
      ready = 1'($urandom_range(0, 1)); rsp_v = 1'($urandom_range(0, 1)); rsp_d = $urandom;
      #1;
      chk("done_stall", 32'(stall), 0);
      chk("done_valid", 32'(valid), 0);
      chk("done_load", load_data, exp_ld);
    end
    @(negedge clk);
    ltype = LS_N_A; wen = 1'b0; ready = 1'b0; rsp_v = 1'b0;
    #1;
    chk("after_stall", 32'(stall), 0);
    chk("after_load", load_data, exp_ld);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_be", 32'(be), 0);
    chk("rst_addr", maddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_load", load_data, 0);
    rst_n = 1'b1;
    access(S_B, 1'b1, 32'h1003, 32'h0000_00A5, 0, 1, 0);
    access(L_B, 1'b0, 32'h2001, 0, 0, 2, 32'h0000_8000);
    chk("dir_lb", load_data, 32'hFFFF_FF80);
    access(L_BU, 1'b0, 32'h2001, 0, 0, 2, 32'h0000_8000);
    chk("dir_lbu", load_data, 32'h0000_0080);
    access(L_H, 1'b0, 32'h2002, 0, 0, 1, 32'h8001_0000);
    chk("dir_lh", load_data, 32'hFFFF_8001);
    access(L_HU, 1'b0, 32'h2002, 0, 0, 1, 32'h8001_0000);
    chk("dir_lhu", load_data, 32'h0000_8001);
    access(L_W, 1'b0, 32'h3002, 0, 0, 1, 32'h1234_5678);
    chk("dir_mis_hold", load_data, 32'h0000_8001);
    access(S_W, 1'b1, 32'h3000, 32'hDEAD_BEEF, 3, 1, 0);
    access(S_H, 1'b0, 32'h3000, 32'hDEAD_BEEF, 0, 1, 0);
    access(S_H, 1'b1, 32'h3006, 32'h0000_BEEF, 1, 1, 0);
    access(L_W, 1'b0, 32'h3004, 0, 1, 3, 32'hCAFE_F00D);
    chk("dir_lw", load_data, 32'hCAFE_F00D);
    // Reset while waiting for a load response; the late response must be dropped.
    @(negedge clk);
    ltype = L_W; a = 32'h4000; #1;
    @(negedge clk);
    ready = 1'b1; #1;
    chk("rst_mid_valid", 32'(valid), 1);
    @(negedge clk);
    ready = 1'b0; rst_n = 1'b0; #1;
    chk("rst_mid_wait_stall", 32'(stall), 1);
    @(negedge clk);
    rst_n = 1'b1; ltype = LS_N_A; rsp_v = 1'b1; rsp_d = 32'h1234_5678; #1;
    exp_ld = '0;
    chk("rst_mid_stall", 32'(stall), 0);
    chk("rst_mid_valid0", 32'(valid), 0);
    chk("rst_mid_load", load_data, 0);
    @(negedge clk);
    rsp_v = 1'b0; #1;
    chk("rst_mid_ignored", load_data, 0);
    chk("rst_mid_stall2", 32'(stall), 0);
    for (int i = 0; i < 300; i++)
      access(load_store_type_e'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  in  1  reset, synchronous and active-low.
REQ-004 load_store_type_i  in  load_store_type_e  access kind from the control unit: LS_N_A, L_B, L_H, L_W, L_BU, L_HU, S_B, S_H, S_W.
REQ-005 data_memory_write_enable_i  in  1  store qualifier from the control unit.
REQ-006 addr_i  in  XLEN  effective byte address (ALU result).
REQ-007 store_data_i  in  XLEN  rs2 value.
REQ-008 stall_o  out  1  while high, the core holds PC, instruction and operands, and suppresses the register write.
REQ-009 load_data_o  out  XLEN  formatted load result, routed to RD_MUX_DMEM.
REQ-010 misaligned_o  out  1  misaligned-access flag.
REQ-011 mem_req_valid_o  out  1  and  mem_req_ready_i  in  1  request handshake.
REQ-012 mem_req_addr_o  out  XLEN  word address, with bits [1:0] = 0.
REQ-013 mem_req_we_o  out  1;  mem_req_be_o  out  4;  mem_req_wdata_o  out  XLEN.
REQ-014 mem_rsp_valid_i  in  1;  mem_rsp_rdata_i  in  XLEN  read response.

Function
REQ-015 Access-present rules:
- A store is present only when the type is S_* and data_memory_write_enable_i=1.
- S_* with the write enable at 0 is no access.
- A load is present when the type is L_*; write enable is ignored.
REQ-016 Misalignment rules:
- Halfword with addr_i[0]=1, or word with addr_i[1:0]!=0, is misaligned.
- A misaligned access issues no bus request.
- misaligned_o=1 combinationally in IDLE; stall_o=0.
- load_data_o is unchanged.
REQ-017 The FSM states shall be IDLE, REQ, WAIT_RSP and DONE.
REQ-018 IDLE with an aligned access present: capture type, addr_i, store_data_i; go to REQ.
REQ-019 REQ: mem_req_valid_o=1.
- On mem_req_ready_i=1, a store goes to DONE and a load goes to WAIT_RSP.
- Otherwise the FSM holds REQ, with address, we, be and wdata stable.
REQ-020 WAIT_RSP: on mem_rsp_valid_i=1, register the formatted data into load_data_o and go to DONE.
- mem_rsp_valid_i is ignored in every other state.
REQ-021 DONE: stall_o=0, then go to IDLE unconditionally, so the held instruction is never re-issued.
REQ-022 stall_o = (IDLE and aligned access present) or REQ or WAIT_RSP.
REQ-023 Minimum stall is 2 cycles for a store (ready=1) and 3 cycles for a load (response one cycle after acceptance).
REQ-024 Store byte enables and write data:
- S_B: be = 1<<addr[1:0]; wdata = byte replicated four times.
- S_H: be = addr[1] ? 4'b1100 : 4'b0011; wdata = halfword replicated twice.
- S_W: be = 4'b1111; wdata = store data.
REQ-025 Loads: be=4'b1111 and we=0.
- Lane selection: byte lane = addr[1:0]; halfword lane = addr[1].
- L_B and L_H sign-extend; L_BU and L_HU zero-extend; L_W passes the word unchanged.
REQ-026 load_data_o holds its last value until the next load completes.
- A store leaves load_data_o unchanged.

Reset
REQ-027 rst_n_i=0 at a clock edge forces IDLE, from any state including mid-handshake.
REQ-028 Output values at reset:
- load_data_o=0.
- mem_req_valid_o, mem_req_we_o and stall_o are 0.
- mem_req_be_o, mem_req_addr_o and mem_req_wdata_o are 0.
REQ-029 A response arriving after a reset is ignored.

Verification
REQ-030 S_B, addr 0x1003, data 0x000000A5, ready=1 -> mem_req_valid_o for 1 cycle with addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5; stall_o high 2 cycles.
REQ-031 L_B at 0x2001 with rdata 0x00008000, response 2 cycles after acceptance -> load_data_o=0xFFFFFF80; the same access with L_BU -> 0x00000080.
REQ-032 L_H and L_HU at 0x2002 with rdata 0x80010000 -> 0xFFFF8001 and 0x00008001 respectively.
REQ-033 L_W at 0x3002 -> misaligned_o=1, no mem_req_valid_o, stall_o=0, load_data_o unchanged.
REQ-034 S_W with ready low for 3 cycles -> valid, addr, be, wdata stable and stall_o high throughout; acceptance on cycle 4, then DONE.
REQ-035 rst_n_i=0 during WAIT_RSP, then mem_rsp_valid_i=1 -> FSM in IDLE, load_data_o=0, stall_o=0, response ignored.
